// File: rtl/proc_pkg.sv
// proc_pkg: shared constants for the processor step controller.
// Holds the opcode map, the 2-bit step encoding and the IR field positions.
package proc_pkg;

    // Step encoding; all four 2-bit codes are legal steps.
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    // IR layout: [8:6] opcode, [5:3] X (destination), [2:0] Y (source)
    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int X_MSB  = 5;
    localparam int X_LSB  = 3;
    localparam int Y_MSB  = 2;
    localparam int Y_LSB  = 0;

endpackage

// File: rtl/proc_control_if.sv
// proc_control_if: instruction/run inputs and datapath control strobes.
// The controller uses the slave view; whoever drives Run/IR uses master.
interface proc_control_if;

    logic       Run;
    logic [8:0] IR;
    logic       Gnz;

    logic       IRin;
    logic [7:0] Rout;
    logic       Gout;
    logic       DINout;
    logic [7:0] Rin;
    logic       Ain;
    logic       Gin;
    logic       AddSub;
    logic       Done;

    modport master (
        output Run, IR, Gnz,
        input  IRin, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done
    );

    modport slave (
        input  Run, IR, Gnz,
        output IRin, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done
    );

endinterface

// File: rtl/proc_control_dec3to8.sv
// dec3to8: 3-bit index to one-hot 8-bit register select.
module dec3to8 (
    input  logic [2:0] i_sel,
    output logic [7:0] o_onehot
);

    // Exactly one output bit set for every index value.
    always_comb begin
        o_onehot = 8'b0000_0001 << i_sel;
    end

endmodule

// File: rtl/proc_control.sv
// proc_control: four-step controller for a small bus-based processor.
// Only the step is registered; every strobe is decoded from step, IR and Gnz.
// Optional feature: define PROC_CTRL_MVNZ_EN to make opcode 100 a
// move-if-G-nonzero; otherwise opcode 100 is a no-op and Gnz is ignored.
//
// state | meaning
// T0    | idle / fetch: IRin follows Run, advance on Run
// T1    | first execute step (mv, mvi, mvnz, no-op finish here)
// T2    | add/sub: second operand onto bus, ALU result into G
// T3    | add/sub: G written back to Rx, Done
module proc_control
    import proc_pkg::*;
(
    input  logic           Clock,
    input  logic           Reset,
    proc_control_if.slave  bus
);

    state_t     r_state;
    state_t     w_state_next;

    logic [2:0] w_op;
    logic [2:0] w_x;
    logic [2:0] w_y;
    logic [7:0] w_x_dec;
    logic [7:0] w_y_dec;
    logic       w_is_addsub;

    logic       w_irin;
    logic [7:0] w_rout;
    logic       w_gout;
    logic       w_dinout;
    logic [7:0] w_rin;
    logic       w_ain;
    logic       w_gin;
    logic       w_addsub;
    logic       w_done;

    assign w_op = bus.IR[OP_MSB:OP_LSB];
    assign w_x  = bus.IR[X_MSB:X_LSB];
    assign w_y  = bus.IR[Y_MSB:Y_LSB];

    assign w_is_addsub = (w_op == OP_ADD) || (w_op == OP_SUB);

`ifndef PROC_CTRL_MVNZ_EN
    logic w_unused_gnz;
    assign w_unused_gnz = bus.Gnz;
`endif

    dec3to8 u_dec_x (
        .i_sel    (w_x),
        .o_onehot (w_x_dec)
    );

    dec3to8 u_dec_y (
        .i_sel    (w_y),
        .o_onehot (w_y_dec)
    );

    // Step register; reset abandons any instruction in flight.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= T0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Step sequencing: only add/sub go past T1; Run matters only in T0.
    always_comb begin
        w_state_next = T0;
        case (r_state)
            T0:      w_state_next = bus.Run ? T1 : T0;
            T1:      w_state_next = w_is_addsub ? T2 : T0;
            T2:      w_state_next = T3;
            T3:      w_state_next = T0;
            default: w_state_next = T0;
        endcase
    end

    // Strobe decode; a single bus source is selected in every branch.
    always_comb begin
        w_irin   = 1'b0;
        w_rout   = 8'h00;
        w_gout   = 1'b0;
        w_dinout = 1'b0;
        w_rin    = 8'h00;
        w_ain    = 1'b0;
        w_gin    = 1'b0;
        w_addsub = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            T0: begin
                w_irin = bus.Run;
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        w_rout = w_y_dec;
                        w_rin  = w_x_dec;
                        w_done = 1'b1;
                    end
                    OP_MVI: begin
                        w_dinout = 1'b1;
                        w_rin    = w_x_dec;
                        w_done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_rout = w_x_dec;
                        w_ain  = 1'b1;
                    end
`ifdef PROC_CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        w_rout = w_y_dec;
                        w_rin  = bus.Gnz ? w_x_dec : 8'h00;
                        w_done = 1'b1;
                    end
`endif
                    default: begin
                        w_done = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (w_is_addsub) begin
                    w_rout   = w_y_dec;
                    w_gin    = 1'b1;
                    w_addsub = (w_op == OP_SUB);
                end
            end
            T3: begin
                // Done is unconditional so the machine always closes out.
                w_done = 1'b1;
                if (w_is_addsub) begin
                    w_gout = 1'b1;
                    w_rin  = w_x_dec;
                end
            end
            default: begin
                w_irin = 1'b0;
            end
        endcase
    end

    assign bus.IRin   = w_irin;
    assign bus.Rout   = w_rout;
    assign bus.Gout   = w_gout;
    assign bus.DINout = w_dinout;
    assign bus.Rin    = w_rin;
    assign bus.Ain    = w_ain;
    assign bus.Gin    = w_gin;
    assign bus.AddSub = w_addsub;
    assign bus.Done   = w_done;

endmodule

// File: doc/proc_control.md
PROC_CONTROL -- requirements
Module: proc_control

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (9-bit instruction, 8 registers).
REQ-002 Clock  input  1  single clock; all state changes on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Run  input  1  start request, sampled only in state T0.
REQ-005 IR  input  9  instruction register contents: IR[8:6] opcode, IR[5:3] X (destination), IR[2:0] Y (source).
REQ-006 Gnz  input  1  G register is non-zero; used only when PROC_CTRL_MVNZ_EN is defined.
REQ-007 IRin  output  1  load the instruction register from DIN.
REQ-008 Rout  output  8  one-hot or all-zero bus source select, bit i selects Ri.
REQ-009 Gout  output  1  drive G onto the bus.
REQ-010 DINout  output  1  drive DIN onto the bus.
REQ-011 Rin  output  8  one-hot or all-zero register write enable, bit i loads Ri from the bus.
REQ-012 Ain  output  1  load register A from the bus.
REQ-013 Gin  output  1  load register G from the ALU.
REQ-014 AddSub  output  1  ALU operation: 0 add, 1 subtract.
REQ-015 Done  output  1  final step of the current instruction.

Function
REQ-016 The block SHALL be a four-state step machine: T0, T1, T2, T3.
- Outputs are a combinational decode of state, IR and Gnz.
- Only the state is registered.
REQ-017 Every output SHALL be 0 unless a rule below drives it high.
REQ-018 At most one bus source SHALL be active in any cycle: Rout, Gout, DINout.
REQ-019 In T0, IRin SHALL equal Run.
- Run=1: next state T1.
- Run=0: stay in T0.
REQ-020 mv (000), T1: Rout=dec(Y), Rin=dec(X), Done=1; next state T0.
REQ-021 mvi (001), T1: DINout=1, Rin=dec(X), Done=1; next state T0.
REQ-022 add (010) / sub (011):
- T1: Rout=dec(X), Ain=1.
- T2: Rout=dec(Y), Gin=1, AddSub = 0 for add / 1 for sub.
- T3: Gout=1, Rin=dec(X), Done=1; next state T0.
REQ-023 Any opcode not enabled SHALL be a no-op: T1 drives Done=1 only; next state T0.
REQ-024 Instruction latency, counted from the IRin cycle to the Done cycle inclusive:
- mv, mvi, no-op: 2 cycles.
- add, sub: 4 cycles.
REQ-025 Run SHALL be ignored in T1–T3.
REQ-026 Back-to-back issue: a new instruction SHALL be fetched in the cycle after Done when Run=1.
REQ-027 X=Y SHALL be legal and SHALL decode normally (e.g. add R2,R2 doubles R2).
REQ-028 The state register SHALL never leave {T0..T3}; an unreachable encoding SHALL return to T0.

Reset
REQ-029 Asserting Reset SHALL force state T0 immediately, independent of Clock, and all outputs except IRin (which follows Run) SHALL read 0.
REQ-030 Reset asserted mid-instruction SHALL abandon it: no further Rin/Ain/Gin pulses, and Done is not asserted.
REQ-031 After Reset deasserts, the first rising edge with Run=1 SHALL fetch normally.

Configuration
REQ-032 Macro PROC_CTRL_MVNZ_EN:
- Defined: opcode 100 is mvnz. In T1: Rout=dec(Y); Rin=dec(X) only if Gnz=1; Done=1; next state T0.
- Undefined: opcode 100 is a no-op per REQ-023, and Gnz is unused.

Structure
REQ-033 Package proc_pkg SHALL hold:
- opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ;
- the state encoding T0..T3 (2-bit);
- field-slice positions for opcode, X and Y.
REQ-034 A sub-module dec3to8 (3-bit to one-hot 8-bit) SHALL be instantiated twice, once for X and once for Y.

Verification
REQ-035 Reset, Run=0 for 5 cycles -> state T0; all outputs 0; IRin=0.
REQ-036 mvi R3 (IR=001_011_000), Run=1 -> IRin=1 in T0; next cycle DINout=1, Rin=8'h08, Done=1.
REQ-037 add R1,R5 (IR=010_001_101):
- T1: Rout=8'h02, Ain=1.
- T2: Rout=8'h20, Gin=1, AddSub=0.
- T3: Gout=1, Rin=8'h02, Done=1.
- sub (IR=011_001_101): identical sequence except AddSub=1 in T2.
REQ-038 Reset asserted in T2 of an add -> outputs 0 at once; state T0; no Rin or Done pulse follows.
REQ-039 Opcode 100 with Gnz=0, then Gnz=1, X=2, Y=7:
- Macro defined: Rout=8'h80 both times; Rin=0 for the first, 8'h04 for the second.
- Macro undefined: Done only in T1 both times.
REQ-040 Assertion on every cycle of all tests: Rout and Rin are each one-hot or zero, and at most one of Rout-nonzero, Gout, DINout is active.
